nec_ir_receiver: RTL and testbench
==================================

Name: nec_ir_receiver

Overview:
- Wishbone-slave peripheral in the user project area that decodes NEC infrared remote frames from one demodulated IR input pin.
- Firmware programs a timing divider and polarity, then polls or takes an interrupt.
- Firmware reads the decoded address and command bytes.

Parameters:
- DEFAULT_DIV, 2812: reset value of DIVIDER. Clock cycles per sub-tick; one sub-tick = T/8, T = 562.5 us NEC base period at 40 MHz.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address; only [3:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- ir_in  in  1  demodulated IR line (asynchronous)
- irq_o  out  1  level interrupt

Behaviour:
- Register map, selected by adr[3:2]; sel honoured per byte on writes:
  - 0 CTRL: bit0 enable, bit1 polarity (0 = burst when line low), bit2 irq_en, bit3 repeat_en.
  - 1 DIVIDER [15:0].
  - 2 DATA (read-only): [7:0] cmd, [15:8] addr, [16] valid, [17] repeat, [18] error. Reading DATA clears bits 16-18.
  - 3: reads 0.
- Wishbone: ack is a one-cycle pulse one cycle after cyc&stb with ack low. Read data is registered with ack.
- Reset values: CTRL=0, DIVIDER=DEFAULT_DIV, DATA=0, ack=0, irq_o=0, FSM=IDLE.
- Input path: 2-flop synchronizer, then XOR with ~polarity, giving "active" (burst present).
- Prescaler counts to DIVIDER-1 and emits a sub-tick strobe. The 8-bit duration counter counts sub-ticks, saturates at 255, and clears on every active/inactive edge.
- FSM states: IDLE, LEAD_BURST, LEAD_SPACE, BIT_BURST, BIT_SPACE, STOP_BURST. Windows are inclusive, in sub-ticks:
  - IDLE -> LEAD_BURST on active rising edge.
  - LEAD_BURST ends on falling edge: duration 96..160 -> LEAD_SPACE, otherwise IDLE.
  - LEAD_SPACE ends on rising edge:
    - 48..80 -> BIT_BURST, bit index 0 (frame).
    - 24..40 -> STOP_BURST flagged as repeat.
    - otherwise IDLE.
  - BIT_BURST: falling edge at 4..12 -> BIT_SPACE, otherwise IDLE.
  - BIT_SPACE ends on rising edge:
    - 4..12 -> shift in 0.
    - 16..32 -> shift in 1.
    - otherwise IDLE.
    - After bit 31 -> STOP_BURST, else BIT_BURST.
  - STOP_BURST: falling edge at 4..12 -> commit, then IDLE; otherwise IDLE without commit.
  - In any non-IDLE state, a counter exceeding the state's window max aborts to IDLE.
- Bits are LSB first. Shift register byte0=addr, byte1=~addr, byte2=cmd, byte3=~cmd.
- Commit (frame), checks pass (byte1==~byte0, byte3==~byte2): load addr/cmd, set valid, clear repeat.
- Commit (frame), check fails: set error only; addr/cmd/valid unchanged.
- Commit (repeat): if repeat_en, set repeat; addr/cmd unchanged.
- New commits overwrite unread data (no overrun flag). A commit in the same cycle as a DATA read wins: flags end set.
- enable=0 holds the FSM in IDLE synchronously; registers are retained. Asynchronous reset mid-frame returns to IDLE immediately.
- irq_o = irq_en & (valid | error), registered.
- Extended NEC (non-inverted address) is not supported and is reported as an error.

Decomposition:
- Package nec_ir_pkg holds:
  - register offsets;
  - CTRL bit indices;
  - DATA bit indices;
  - FSM state enum;
  - window constants (96/160/48/80/24/40/4/12/16/32).
- One sub-module, nec_ir_decoder: synchronizer, prescaler, duration counter, FSM. Outputs are a commit pulse, frame/repeat/error flags and 32-bit data.
- The top level holds the Wishbone registers and irq.

Test Plan:
- Reset -> read CTRL=0, DIVIDER=0x00000AFC, DATA=0, irq_o=0.
- Set DIVIDER=281, CTRL=0x5. Send a frame (T=56.25 us, active-low) with addr 0xA5, cmd 0x3C -> DATA=0x0001A53C and irq_o=1. Re-read DATA -> 0x0000A53C and irq_o=0.
- Frame with byte1 corrupted (0x00) -> DATA bit18 set, bit16 0, addr/cmd still 0xA5/0x3C.
- CTRL=0xD, valid frame, then a repeat code (9 ms-equivalent burst, 4T space, stop burst) -> DATA bit17 set, addr/cmd unchanged.
- Leader burst of 180 sub-ticks, then a valid frame addr 0x12, cmd 0x34 -> first is ignored, DATA=0x00011234.
- Assert wb_rst_i at bit 15 of a frame -> no commit. Registers return to reset values. After reprogramming, the next full frame decodes.

Source files
------------

// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: register map, bit positions, decoder states and pulse windows in sub-ticks
package nec_ir_pkg;
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_DIV  = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam int CTRL_EN  = 0;
    localparam int CTRL_POL = 1;
    localparam int CTRL_IRQ = 2;
    localparam int CTRL_REP = 3;
    localparam int DATA_VALID = 16;
    localparam int DATA_REP   = 17;
    localparam int DATA_ERR   = 18;
    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_BURST, S_LEAD_SPACE, S_BIT_BURST, S_BIT_SPACE, S_STOP_BURST
    } state_t;
    localparam logic [7:0] LEAD_MIN = 8'd96;
    localparam logic [7:0] LEAD_MAX = 8'd160;
    localparam logic [7:0] HDR_MIN  = 8'd48;
    localparam logic [7:0] HDR_MAX  = 8'd80;
    localparam logic [7:0] RPT_MIN  = 8'd24;
    localparam logic [7:0] RPT_MAX  = 8'd40;
    localparam logic [7:0] BIT_MIN  = 8'd4;
    localparam logic [7:0] BIT_MAX  = 8'd12;
    localparam logic [7:0] ONE_MIN  = 8'd16;
    localparam logic [7:0] ONE_MAX  = 8'd32;
    function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction
endpackage

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: synchronizes the IR line, times bursts/spaces in sub-ticks and decodes NEC frames
module nec_ir_decoder
    import nec_ir_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ir,
    input  logic        i_en,
    input  logic        i_pol,
    input  logic [15:0] i_div,
    output logic        o_commit,
    output logic        o_frame,
    output logic        o_repeat,
    output logic        o_error,
    output logic [31:0] o_data
);
    logic [1:0]  r_sync;
    logic        r_act;
    logic [15:0] r_pre;
    logic [7:0]  r_dur;
    logic [4:0]  r_bit;
    logic [31:0] r_shift;
    logic        r_rep;
    state_t      r_state, w_next;
    logic        w_act, w_rise, w_fall, w_tick, w_shift, w_commit;
    logic [7:0]  w_max;

    assign w_act  = r_sync[1] ^ ~i_pol;
    assign w_rise = w_act & ~r_act;
    assign w_fall = ~w_act & r_act;
    assign w_tick = ({1'b0, r_pre} + 17'd1) >= {1'b0, i_div};
    assign w_max  = (r_state == S_LEAD_BURST) ? LEAD_MAX :
                    (r_state == S_LEAD_SPACE) ? HDR_MAX :
                    (r_state == S_BIT_SPACE)  ? ONE_MAX : BIT_MAX;

    always_comb begin
        w_next   = r_state;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE:       if (w_rise) w_next = S_LEAD_BURST;
            S_LEAD_BURST: if (w_fall) w_next = in_win(r_dur, LEAD_MIN, LEAD_MAX) ? S_LEAD_SPACE : S_IDLE;
            S_LEAD_SPACE: if (w_rise) w_next = in_win(r_dur, HDR_MIN, HDR_MAX) ? S_BIT_BURST :
                                               in_win(r_dur, RPT_MIN, RPT_MAX) ? S_STOP_BURST : S_IDLE;
            S_BIT_BURST:  if (w_fall) w_next = in_win(r_dur, BIT_MIN, BIT_MAX) ? S_BIT_SPACE : S_IDLE;
            S_BIT_SPACE:  if (w_rise) begin
                w_shift = in_win(r_dur, BIT_MIN, BIT_MAX) || in_win(r_dur, ONE_MIN, ONE_MAX);
                w_next  = !w_shift ? S_IDLE : (r_bit == 5'd31) ? S_STOP_BURST : S_BIT_BURST;
            end
            S_STOP_BURST: if (w_fall) begin
                w_commit = in_win(r_dur, BIT_MIN, BIT_MAX);
                w_next   = S_IDLE;
            end
            default:      w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && !w_rise && !w_fall && r_dur > w_max) w_next = S_IDLE;
        if (!i_en) begin
            w_next   = S_IDLE;
            w_commit = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_act   <= 1'b0;
            r_pre   <= '0;
            r_dur   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_ir};
            r_act  <= w_act;
            r_pre  <= w_tick ? '0 : r_pre + 16'd1;
            r_dur  <= (w_rise || w_fall) ? '0 : (w_tick && r_dur != 8'hff) ? r_dur + 8'd1 : r_dur;
            if (r_state == S_LEAD_SPACE) begin
                r_bit <= '0;
                r_rep <= in_win(r_dur, RPT_MIN, RPT_MAX);
            end else if (w_shift) r_bit <= r_bit + 5'd1;
            if (w_shift) r_shift <= {r_dur >= ONE_MIN, r_shift[31:1]};
        end
    end

    assign o_commit = w_commit;
    assign o_frame  = ~r_rep;
    assign o_repeat = r_rep;
    assign o_error  = ~r_rep & ((r_shift[15:8] != ~r_shift[7:0]) || (r_shift[31:24] != ~r_shift[23:16]));
    assign o_data   = r_shift;
endmodule

// File: rtl/nec_ir_receiver.sv
// nec_ir_receiver: Wishbone register front end and interrupt for the NEC IR decoder
module nec_ir_receiver
    import nec_ir_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd2812
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ir_in,
    output logic        irq_o
);
    logic [3:0]  r_ctrl;
    logic [15:0] r_div;
    logic [7:0]  r_addr, r_cmd;
    logic        r_valid, r_rep, r_err, r_ack, r_irq;
    logic [31:0] r_dat;
    logic        w_commit, w_frame, w_repeat, w_error, w_acc, w_wr, w_rd_data, w_unused;
    logic [1:0]  w_adr;
    logic [31:0] w_data, w_rdata;

    nec_ir_decoder u_dec (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_ir     (ir_in),
        .i_en     (r_ctrl[CTRL_EN]),
        .i_pol    (r_ctrl[CTRL_POL]),
        .i_div    (r_div),
        .o_commit (w_commit),
        .o_frame  (w_frame),
        .o_repeat (w_repeat),
        .o_error  (w_error),
        .o_data   (w_data)
    );

    assign w_adr     = wbs_adr_i[3:2];
    assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_rd_data = w_acc & ~wbs_we_i & (w_adr == REG_DATA);
    assign w_rdata   = (w_adr == REG_CTRL) ? {28'd0, r_ctrl} :
                       (w_adr == REG_DIV)  ? {16'd0, r_div} :
                       (w_adr == REG_DATA) ? {13'd0, r_err, r_rep, r_valid, r_addr, r_cmd} : 32'd0;
    assign w_unused  = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ctrl  <= '0;
            r_div   <= DEFAULT_DIV;
            r_addr  <= '0;
            r_cmd   <= '0;
            r_valid <= 1'b0;
            r_rep   <= 1'b0;
            r_err   <= 1'b0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ack <= w_acc;
            if (w_acc) r_dat <= w_rdata;
            if (w_wr && w_adr == REG_CTRL && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[3:0];
            if (w_wr && w_adr == REG_DIV && wbs_sel_i[0]) r_div[7:0] <= wbs_dat_i[7:0];
            if (w_wr && w_adr == REG_DIV && wbs_sel_i[1]) r_div[15:8] <= wbs_dat_i[15:8];
            // a commit landing on the same cycle as a DATA read overrides the read-clear
            if (w_rd_data) {r_err, r_rep, r_valid} <= 3'b000;
            if (w_commit && w_frame && !w_error) begin
                r_addr  <= w_data[7:0];
                r_cmd   <= w_data[23:16];
                r_valid <= 1'b1;
                r_rep   <= 1'b0;
            end
            if (w_commit && w_error) r_err <= 1'b1;
            if (w_commit && w_repeat && r_ctrl[CTRL_REP]) r_rep <= 1'b1;
            r_irq <= r_ctrl[CTRL_IRQ] & (r_valid | r_err);
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_irq;
endmodule

// File: tb/tb_nec_ir_receiver.sv
// tb_nec_ir_receiver: directed NEC frames driven on an active-low IR line, checked through Wishbone reads
module tb_nec_ir_receiver;
    localparam int DIV = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack, irq;
    logic [31:0] rdat;
    logic        ir = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] v;

    nec_ir_receiver dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .ir_in     (ir),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] r);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 8);
        r = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("wb_ack", {31'd0, ack}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, s, r);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, 4'hf, r);
        check(tag, r, exp);
    endtask

    task automatic phase(input logic act, input int n);
        ir = act ? 1'b0 : 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int nbits);
        phase(1'b1, 128);
        phase(1'b0, 64);
        for (int i = 0; i < nbits; i++) begin
            phase(1'b1, 8);
            phase(1'b0, bits[i] ? 24 : 8);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] na, input logic [7:0] c, input logic [7:0] nc);
        send_bits({nc, c, na, a}, 32);
        phase(1'b1, 8);
        phase(1'b0, 40);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_check("rst_ctrl", 32'h0, 32'h0);
        rd_check("rst_div", 32'h4, 32'h0000_0AFC);
        rd_check("rst_data", 32'h8, 32'h0);
        rd_check("rst_reg3", 32'hC, 32'h0);

        wr(32'h4, 32'd281, 4'hf);
        rd_check("div_281", 32'h4, 32'd281);
        wr(32'h4, 32'h0000_FF04, 4'b0001);
        rd_check("div_sel", 32'h4, 32'h0000_0104);
        wr(32'h4, DIV, 4'hf);
        wr(32'h0, 32'h5, 4'hf);
        rd_check("ctrl_5", 32'h0, 32'h5);

        send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3);
        check("frame1_irq", {31'd0, irq}, 32'd1);
        rd_check("frame1_data", 32'h8, 32'h0001_A53C);
        repeat (3) @(negedge clk);
        check("frame1_irq_clr", {31'd0, irq}, 32'd0);
        rd_check("frame1_reread", 32'h8, 32'h0000_A53C);

        send_frame(8'hA5, 8'h00, 8'h3C, 8'hC3);
        check("err_irq", {31'd0, irq}, 32'd1);
        rd_check("err_data", 32'h8, 32'h0004_A53C);

        wr(32'h0, 32'hD, 4'hf);
        send_frame(8'h66, 8'h99, 8'h81, 8'h7E);
        rd_check("frame2_data", 32'h8, 32'h0001_6681);
        phase(1'b1, 128);
        phase(1'b0, 32);
        phase(1'b1, 8);
        phase(1'b0, 40);
        rd_check("repeat_data", 32'h8, 32'h0002_6681);
        rd_check("repeat_clr", 32'h8, 32'h0000_6681);

        phase(1'b1, 180);
        phase(1'b0, 100);
        send_frame(8'h12, 8'hED, 8'h34, 8'hCB);
        rd_check("long_lead", 32'h8, 32'h0001_1234);

        wr(32'h0, 32'h4, 4'hf);
        send_frame(8'h55, 8'hAA, 8'hF0, 8'h0F);
        rd_check("disabled_data", 32'h8, 32'h0000_1234);
        check("disabled_irq", {31'd0, irq}, 32'd0);

        wr(32'h0, 32'h5, 4'hf);
        send_bits({8'h77, 8'h88, 8'h88, 8'h77}, 15);
        phase(1'b1, 4);
        rst = 1'b1;
        ir = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        rd_check("midrst_ctrl", 32'h0, 32'h0);
        rd_check("midrst_div", 32'h4, 32'h0000_0AFC);
        rd_check("midrst_data", 32'h8, 32'h0);

        wr(32'h4, DIV, 4'hf);
        wr(32'h0, 32'h5, 4'hf);
        send_frame(8'h77, 8'h88, 8'h88, 8'h77);
        check("after_rst_irq", {31'd0, irq}, 32'd1);
        rd_check("after_rst_data", 32'h8, 32'h0001_7788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
